// File: rtl/tree_adder_arbiter.sv
// Round-robin front end for one shared pipelined TreeAdder, with a valid/ID tag pipeline matched to adder latency.
// Optional per-requester handshake counters are enabled by defining TREE_ADDER_ARB_STATS_EN.
module tree_adder_arbiter #(
    parameter int WORD_WIDTH    = 8,
    parameter int NUM_TERMS     = 9,
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 4,
    parameter int ADDER_LATENCY = $clog2(NUM_TERMS)
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [NUM_REQ-1:0]                      i_req_valid,
    output logic [NUM_REQ-1:0]                      o_req_ready,
    input  logic [NUM_REQ*NUM_TERMS*WORD_WIDTH-1:0] i_req_terms,
    input  logic                                    i_pause,
`ifdef TREE_ADDER_ARB_STATS_EN
    input  logic                                    i_stats_clr,
    output logic [NUM_REQ*16-1:0]                   o_grant_cnt,
`endif
    output logic [NUM_TERMS*WORD_WIDTH-1:0]         o_add_terms,
    input  logic [WORD_WIDTH-1:0]                   i_add_sum,
    output logic                                    o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]              o_rsp_id,
    output logic [WORD_WIDTH-1:0]                   o_rsp_sum,
    output logic                                    o_busy
);
    localparam int IDW    = $clog2(NUM_REQ);
    localparam int SLW    = NUM_TERMS * WORD_WIDTH;
    localparam int STAGES = ADDER_LATENCY;
    localparam int CNTW   = $clog2(MAX_BURST + 1);

    if (NUM_TERMS < 2) begin : g_bad_terms
        $error("tree_adder_arbiter: NUM_TERMS must be >= 2");
    end
    if (NUM_REQ < 2) begin : g_bad_req
        $error("tree_adder_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("tree_adder_arbiter: MAX_BURST must be >= 1");
    end
    if (ADDER_LATENCY < 1) begin : g_bad_lat
        $error("tree_adder_arbiter: ADDER_LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                   state;
    logic [IDW-1:0]           rr_ptr;
    logic [CNTW-1:0]          burst_cnt;
    logic [STAGES:0]          vld_pipe;
    logic [STAGES:0][IDW-1:0] id_pipe;

    logic [NUM_REQ-1:0][SLW-1:0] req_slice;
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
        assign req_slice[r] = i_req_terms[r*SLW +: SLW];
    end

    // First valid requester at or after rr_ptr. While a requester owns the
    // burst, rr_ptr points at it, so it keeps priority until it lets go.
    logic           win_found;
    logic [IDW-1:0] win_id;
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && i_req_valid[IDW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    logic hs;
    assign hs = (state == S_RUN) && !i_pause && !i_rst && win_found;

    always_comb begin
        o_req_ready = '0;
        if (hs) o_req_ready[win_id] = 1'b1;
    end

    logic [IDW-1:0]  win_nxt, rr_nxt;
    logic [CNTW-1:0] cnt_inc;
    assign win_nxt = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    assign rr_nxt  = (rr_ptr == IDW'(NUM_REQ - 1)) ? '0 : rr_ptr + 1'b1;
    assign cnt_inc = (win_id == rr_ptr) ? burst_cnt + 1'b1 : CNTW'(1);

    // Pipeline is empty after this edge once nothing sits below the last stage
    // (no handshake can enter outside RUN, and none happens without a valid).
    logic drain_done;
    assign drain_done = (vld_pipe[STAGES-1:0] == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (|i_req_valid && !i_pause) state <= S_RUN;
                S_RUN:   if (i_pause) state <= S_DRAIN;
                         else if (!(|i_req_valid) && drain_done) state <= S_IDLE;
                S_DRAIN: if (drain_done) state <= S_IDLE;
                         else if (!i_pause) state <= S_RUN;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (hs) begin
            if (cnt_inc == CNTW'(MAX_BURST)) begin
                rr_ptr    <= win_nxt;
                burst_cnt <= '0;
            end else begin
                rr_ptr    <= win_id;
                burst_cnt <= cnt_inc;
            end
        end else if (burst_cnt != '0 && !i_req_valid[rr_ptr]) begin
            rr_ptr    <= rr_nxt;
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe    <= '0;
            id_pipe     <= '0;
            o_add_terms <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], hs};
            id_pipe  <= {id_pipe[STAGES-1:0], win_id};
            if (hs) o_add_terms <= req_slice[win_id];
        end
    end

    assign o_rsp_valid = vld_pipe[STAGES];
    assign o_rsp_id    = id_pipe[STAGES];
    assign o_rsp_sum   = i_add_sum;
    assign o_busy      = (state != S_IDLE) || (|vld_pipe);

`ifdef TREE_ADDER_ARB_STATS_EN
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge i_clk) begin
            if (i_rst || i_stats_clr) cnt <= '0;
            else if (o_req_ready[r] && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
        end
        assign o_grant_cnt[r*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_tree_adder_arbiter.sv
// Directed bench for tree_adder_arbiter with a behavioural 2-stage adder and an in-order response scoreboard.
module tb_tree_adder_arbiter;
    localparam int W   = 8;
    localparam int NT  = 3;
    localparam int NR  = 3;
    localparam int MB  = 2;
    localparam int AL  = 2;
    localparam int SLW = NT * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*SLW-1:0] req_terms;
    logic              pause;
    logic [SLW-1:0]    add_terms;
    logic [W-1:0]      add_sum;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              busy;
`ifdef TREE_ADDER_ARB_STATS_EN
    logic              stats_clr;
    logic [NR*16-1:0]  grant_cnt;
`endif

    tree_adder_arbiter #(
        .WORD_WIDTH(W), .NUM_TERMS(NT), .NUM_REQ(NR), .MAX_BURST(MB), .ADDER_LATENCY(AL)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_terms (req_terms),
        .i_pause     (pause),
`ifdef TREE_ADDER_ARB_STATS_EN
        .i_stats_clr (stats_clr),
        .o_grant_cnt (grant_cnt),
`endif
        .o_add_terms (add_terms),
        .i_add_sum   (add_sum),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_busy      (busy)
    );

    function automatic logic [W-1:0] sum_slice(input logic [SLW-1:0] s);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < NT; k++) acc = acc + s[k*W +: W];
        return acc;
    endfunction

    // Stand-in for the shared TreeAdder: AL register stages, wrapping sum.
    logic [W-1:0] add_s1, add_s2;
    always @(posedge clk) begin
        add_s1 <= sum_slice(add_terms);
        add_s2 <= add_s1;
    end
    assign add_sum = add_s2;

    typedef struct {
        int           id;
        logic [W-1:0] sum;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   hs_q[$];
    int   hs_cyc[$];
    int   cyc;
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (req_ready != '0) begin
            chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            chk("ready_has_valid", 64'(req_ready & ~req_valid), 64'd0);
            for (int r = 0; r < NR; r++) begin
                if (req_ready[r]) begin
                    e.id  = r;
                    e.sum = sum_slice(req_terms[r*SLW +: SLW]);
                    e.cyc = cyc;
                    sb.push_back(e);
                    hs_q.push_back(r);
                    hs_cyc.push_back(cyc);
                end
            end
        end
        if (rsp_valid) begin
            chk("rsp_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                chk("rsp_latency", 64'(cyc - e.cyc), 64'(1 + AL));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k;
        k = 0;
        while (hs_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("hs_timeout", 64'(hs_q.size() >= n), 64'd1);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
        chk("drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic set_terms(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c);
        req_terms[r*SLW +: SLW] = {c, b, a};
    endtask

    task automatic one_shot(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] exp_sum);
        int h;
        set_terms(r, a, b, c);
        hs_q.delete();
        hs_cyc.delete();
        req_valid = NR'(1 << r);
        wait_hs(1, 10);
        req_valid = '0;
        h = (hs_cyc.size() > 0) ? hs_cyc[0] : -100;
        chk("issue_terms", 64'(add_terms), 64'({c, b, a}));
        for (int k = 0; k < 5; k++) begin
            chk("rsp_window", 64'(rsp_valid), 64'(cyc == h + 1 + AL));
            if (cyc == h + 1 + AL) begin
                chk("rsp_id_direct", 64'(rsp_id), 64'(r));
                chk("rsp_sum_direct", 64'(rsp_sum), 64'(exp_sum));
            end
            step();
        end
    endtask

    initial begin
        int exp_order[8];
        int h;
        exp_order = '{0, 0, 2, 2, 0, 0, 2, 2};
        cyc = 0; checks = 0; errors = 0;
        rst = 1'b1; req_valid = '0; req_terms = '0; pause = 1'b0;
`ifdef TREE_ADDER_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        step();
        step();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_add_terms", 64'(add_terms), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Burst limit: req0 and req2 alternate in pairs, one grant per cycle.
        set_terms(0, 8'd10, 8'd11, 8'd12);
        set_terms(1, 8'd20, 8'd21, 8'd22);
        set_terms(2, 8'd30, 8'd31, 8'd32);
        hs_q.delete(); hs_cyc.delete();
        req_valid = 3'b101;
        wait_hs(8, 30);
        req_valid = '0;
        for (int i = 0; i < 8; i++)
            chk("burst_order", 64'((i < hs_q.size()) ? hs_q[i] : -1), 64'(exp_order[i]));
        for (int i = 1; i < 8; i++)
            chk("burst_b2b", 64'((i < hs_cyc.size()) ? hs_cyc[i] - hs_cyc[i-1] : -1), 64'd1);
        drain(8);

        one_shot(1, 8'd1, 8'd2, 8'd3, 8'd6);
        one_shot(2, 8'd200, 8'd100, 8'd0, 8'd44);
        one_shot(0, 8'd255, 8'd255, 8'd255, 8'd253);
        drain(4);

        // Pause with three tags in flight.
        set_terms(0, 8'd1, 8'd1, 8'd1);
        set_terms(1, 8'd2, 8'd2, 8'd2);
        set_terms(2, 8'd3, 8'd3, 8'd3);
        hs_q.delete(); hs_cyc.delete();
        req_valid = 3'b111;
        wait_hs(3, 10);
        pause = 1'b1;
        #1;
        h = (hs_cyc.size() >= 3) ? hs_cyc[2] : -100;
        chk("pause_ready", 64'(req_ready), 64'd0);
        chk("pause_inflight", 64'(sb.size()), 64'd3);
        for (int k = 0; k < 5; k++) begin
            chk("pause_no_grant", 64'(req_ready), 64'd0);
            chk("pause_busy", 64'(busy), 64'(cyc <= h + 1 + AL));
            step();
        end
        chk("pause_drained", 64'(sb.size()), 64'd0);
        chk("pause_hs_count", 64'(hs_q.size()), 64'd3);
        pause = 1'b0;
        req_valid = '0;
        step();

        // Reset with two tags in flight; req0 left rr_ptr at 1 before the reset.
        hs_q.delete(); hs_cyc.delete();
        req_valid = 3'b001;
        wait_hs(2, 10);
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        chk("rst_mid_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 5; k++) begin
            chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        hs_q.delete(); hs_cyc.delete();
        req_valid = 3'b111;
        wait_hs(1, 10);
        req_valid = '0;
        chk("rst_first_grant", 64'((hs_q.size() > 0) ? hs_q[0] : -1), 64'd0);
        drain(8);

`ifdef TREE_ADDER_ARB_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        hs_q.delete(); hs_cyc.delete();
        req_valid = 3'b010;
        wait_hs(5, 15);
        chk("stats_pre_clr", 64'(grant_cnt[16 +: 16]), 64'd5);
        stats_clr = 1'b1;
        #1;
        chk("stats_clr_grant", 64'(req_ready), 64'(3'b010));
        step();
        stats_clr = 1'b0;
        req_valid = '0;
        chk("stats_cleared", 64'(grant_cnt[16 +: 16]), 64'd0);
        drain(8);
        hs_q.delete(); hs_cyc.delete();
        req_valid = 3'b010;
        for (int k = 0; k < 65540; k++) step();
        req_valid = '0;
        chk("stats_sat", 64'(grant_cnt[16 +: 16]), 64'd65535);
        chk("stats_other", 64'(grant_cnt[0 +: 16]), 64'd0);
        drain(8);
`endif

        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tree_adder_arbiter.md
Name: tree_adder_arbiter

Overview:
- Shares one pipelined TreeAdder (NUM_TERMS terms, WORD_WIDTH bits) between NUM_REQ requesters.
- Arbitrates round-robin, with a bounded burst per grant.
- Registers the selected term vector into the adder and carries a valid/ID tag pipeline matched to adder latency.
- Returns each sum tagged with the requester ID; sits between the conv window generators and the shared reduction adder.

Parameters:
- WORD_WIDTH, 8, bits per term and per sum.
- NUM_TERMS, 9, terms per request; must be ≥2.
- NUM_REQ, 4, requester count; must be ≥2.
- MAX_BURST, 4, maximum consecutive grants to one requester before rotating; must be ≥1.
- ADDER_LATENCY, $clog2(NUM_TERMS), cycles from adder input to o_sum; must match the instantiated TreeAdder.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  one-hot grant; handshake when valid & ready.
- i_req_terms  in  NUM_REQ*NUM_TERMS*WORD_WIDTH  requester r's terms at slice r.
- i_pause  in  1  stop issuing grants and drain in-flight work.
- o_add_terms  out  NUM_TERMS*WORD_WIDTH  registered terms to the adder's i_terms.
- i_add_sum  in  WORD_WIDTH  adder o_sum.
- o_rsp_valid  out  1  response valid; no backpressure.
- o_rsp_id  out  $clog2(NUM_REQ)  requester owning o_rsp_sum.
- o_rsp_sum  out  WORD_WIDTH  equals i_add_sum, aligned with o_rsp_valid.
- o_busy  out  1  state≠IDLE or any tag in flight.

Behaviour:
- Reset:
  - Tag pipeline valids cleared; in-flight work is dropped.
  - rr_ptr=0, burst_cnt=0, state=IDLE.
  - o_add_terms=0, o_rsp_valid=0, o_rsp_id=0, o_req_ready=0, o_busy=0.
  - o_rsp_sum is don't-care while o_rsp_valid=0.
- FSM:
  - IDLE→RUN: any i_req_valid & !i_pause.
  - RUN→DRAIN: i_pause=1.
  - RUN→IDLE: no i_req_valid and tag pipeline empty.
  - DRAIN→IDLE: tag pipeline empty.
  - DRAIN→RUN: i_pause=0 before the pipeline empties.
- Grant:
  - Only in RUN with i_pause=0; combinational from i_req_valid, rr_ptr and the current owner.
  - o_req_ready is at most one-hot and is never asserted for a requester whose valid is low.
- Round robin:
  - The search starts at rr_ptr. The winner is the first valid requester at or after rr_ptr, wrapping NUM_REQ-1→0.
  - After a handshake by g, burst_cnt increments.
  - Ownership ends when burst_cnt reaches MAX_BURST or g drops valid. Then rr_ptr=(g+1) mod NUM_REQ and burst_cnt=0.
  - While g holds ownership, it keeps the grant with priority over lower rr order.
- Issue:
  - On a handshake at cycle t, o_add_terms loads that requester's slice at edge t+1.
  - Tag {1, id} enters the stage-0 register at the same edge.
  - o_add_terms holds its last value when there is no handshake; only tag valid=0 marks it unused.
- Latency:
  - The tag pipeline is 1+ADDER_LATENCY deep.
  - o_rsp_valid=1 with o_rsp_id=id exactly 1+ADDER_LATENCY cycles after the handshake.
  - o_rsp_sum passes i_add_sum through combinationally.
- Throughput: one handshake per cycle sustained. Back-to-back requests from different requesters stay in order, with no bubbles.
- Arithmetic: sums are modulo 2^WORD_WIDTH (adder wraps); this block adds no width growth.
- Simultaneous events:
  - i_pause rising in the same cycle as a valid request: no grant that cycle.
  - Reset has priority over all events.
- Invalid parameters: $error at elaboration.

Optional Feature:
- Macro TREE_ADDER_ARB_STATS_EN.
- When defined:
  - Adds output o_grant_cnt (NUM_REQ*16 bits): per-requester saturating 16-bit handshake counters, cleared by i_rst.
  - Adds input i_stats_clr (1 bit); it clears all counters on the next edge and takes priority over same-cycle increments.
- When undefined: neither port exists and no counter logic is generated. Core behaviour is identical.

Test Plan:
- Setup: NUM_REQ=3, NUM_TERMS=3 (ADDER_LATENCY=2), WORD_WIDTH=8, MAX_BURST=2, real TreeAdder attached.
- Single request: req1 valid with terms {1,2,3} handshake at t → o_rsp_valid=1, o_rsp_id=1, o_rsp_sum=6 at t+3 only.
- Burst limit: req0 and req2 held valid → grant order 0,0,2,2,0,0… with one grant per cycle; o_rsp_id stream follows the same order, offset by 3 cycles.
- Wrap-around: terms {200,100,0} → o_rsp_sum=44.
- Pause mid-stream: i_pause=1 with 3 tags in flight → o_req_ready=0 immediately; all 3 responses emerge; o_busy falls 1 cycle after the last one; state IDLE.
- Reset mid-operation: i_rst pulsed with 2 tags in flight → no o_rsp_valid afterwards; rr_ptr=0, so the first grant with all valid goes to req0.
- STATS_EN: 5 grants to req1, then i_stats_clr asserted in the same cycle as a 6th grant → count reads 5 before the clear, 0 after it; saturation held at 65535.
